pagerank_iteration_scheduler: RTL and testbench

Top-level iteration controller for the PageRank accelerator. Each iteration it launches the NUM_HW_THREADS partition engines and waits for all of them to finish. It then sequences their partial-rank streams, one partition per cycle, into the serial damping stage. It reads back the stage's delta and either declares convergence, stops at the iteration cap, or clears the damping stage and starts the next iteration.

---
 rtl/pagerank_pkg.sv | 23 ++
 rtl/thread_done_tracker.sv | 41 ++++
 rtl/pagerank_iteration_scheduler.sv | 156 +++++++++++++++
 tb/tb_pagerank_iteration_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank iteration scheduler and its models.
package pagerank_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT_THREADS,
    S_STREAM,
    S_WAIT_DAMP,
    S_CHECK,
    S_DONE
  } sched_state_t;

  // Unsigned fixed-point compare; equality counts as not converged.
  function automatic logic delta_converged(input logic [DATA_W-1:0] delta,
                                           input logic [DATA_W-1:0] epsilon);
    return delta < epsilon;
  endfunction

endpackage

// File: rtl/thread_done_tracker.sv
// Pending-completion mask for the partition engines: set on launch, cleared per done bit.
module thread_done_tracker #(
  parameter int NUM_HW_THREADS = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      set_all,
  input  logic                      track_en,
  input  logic                      clear,
  input  logic [NUM_HW_THREADS-1:0] thread_done,
  output logic                      all_done
);

  logic [NUM_HW_THREADS-1:0] pending;
  logic [NUM_HW_THREADS-1:0] pending_next;

  // all_done looks at the next mask so the last done moves the FSM on the same edge.
  always_comb begin
    pending_next = pending;
    if (set_all) begin
      pending_next = '1;
    end
    if (set_all || track_en) begin
      pending_next = pending_next & ~thread_done;
    end
    if (clear) begin
      pending_next = '0;
    end
  end

  assign all_done = (pending_next == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/pagerank_iteration_scheduler.sv
// Per-iteration controller: launch partition engines, stream partials into damping,
// then decide between convergence, iteration cap, or another round.
module pagerank_iteration_scheduler
  import pagerank_pkg::*;
#(
  parameter int NUM_HW_THREADS = 8,
  parameter int ITER_W         = 16,
  parameter int THREAD_IDX_W   = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DATA_W-1:0]         epsilon,
  input  logic [ITER_W-1:0]         max_iterations,
  output logic [NUM_HW_THREADS-1:0] thread_start,
  input  logic [NUM_HW_THREADS-1:0] thread_done,
  output logic [THREAD_IDX_W-1:0]   stream_sel,
  output logic                      stream_start,
  output logic                      stream_done,
  output logic                      damp_clear,
  input  logic                      damp_complete,
  input  logic [DATA_W-1:0]         delta,
  output logic [ITER_W-1:0]         iteration_count,
  output logic                      busy,
  output logic                      done,
  output logic                      converged,
  output sched_state_t              state_dbg
);

  // Handshakes: thread_start is a one-cycle launch; each engine answers with
  // thread_done (pulse or level), honoured only while its pending bit is set.
  // damp_complete is a level that qualifies delta; damp_clear drops it.

  localparam logic [THREAD_IDX_W-1:0] LAST_SEL = THREAD_IDX_W'(NUM_HW_THREADS - 1);

  sched_state_t              state, state_next;
  logic [THREAD_IDX_W-1:0]   sel_q;
  logic [ITER_W-1:0]         iter_q, cap_q, iter_plus;
  logic [DATA_W-1:0]         eps_q, delta_q;
  logic                      conv_q;
  logic                      set_all, track_en, all_done;
  logic                      is_conv, hit_cap, take_start;

  thread_done_tracker #(
    .NUM_HW_THREADS(NUM_HW_THREADS)
  ) u_tracker (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_all    (set_all),
    .track_en   (track_en),
    .clear      (abort),
    .thread_done(thread_done),
    .all_done   (all_done)
  );

  assign iter_plus  = iter_q + ITER_W'(1);
  assign is_conv    = delta_converged(delta_q, eps_q);
  assign hit_cap    = (iter_plus == cap_q);
  assign take_start = start && !abort && (state == S_IDLE || state == S_DONE);

  always_comb begin
    state_next   = state;
    thread_start = '0;
    damp_clear   = 1'b0;
    stream_start = 1'b0;
    stream_done  = 1'b0;
    set_all      = 1'b0;
    track_en     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        damp_clear = 1'b1;
        state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        thread_start = '1;
        set_all      = 1'b1;
        state_next   = all_done ? S_STREAM : S_WAIT_THREADS;
      end
      S_WAIT_THREADS: begin
        track_en = 1'b1;
        if (all_done) state_next = S_STREAM;
      end
      S_STREAM: begin
        stream_start = (sel_q == '0);
        stream_done  = (sel_q == LAST_SEL);
        if (sel_q == LAST_SEL) state_next = S_WAIT_DAMP;
      end
      S_WAIT_DAMP: begin
        if (damp_complete) state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = (is_conv || hit_cap) ? S_DONE : S_CLEAR;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next   = S_IDLE;
      thread_start = '0;
      damp_clear   = 1'b0;
      stream_start = 1'b0;
      stream_done  = 1'b0;
      set_all      = 1'b0;
      track_en     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eps_q   <= '0;
      cap_q   <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
      delta_q <= '0;
      sel_q   <= '0;
    end else begin
      if (take_start) begin
        eps_q  <= epsilon;
        cap_q  <= (max_iterations == '0) ? ITER_W'(1) : max_iterations;
        iter_q <= '0;
        conv_q <= 1'b0;
      end
      if (state == S_WAIT_DAMP && damp_complete) begin
        delta_q <= delta;
      end
      if (state == S_CHECK && !abort) begin
        iter_q <= iter_plus;
        if (is_conv) conv_q <= 1'b1;
      end
      if (state == S_STREAM && !abort && sel_q != LAST_SEL) begin
        sel_q <= sel_q + THREAD_IDX_W'(1);
      end else begin
        sel_q <= '0;
      end
    end
  end

  assign stream_sel      = (state == S_STREAM) ? sel_q : '0;
  assign iteration_count = iter_q;
  assign converged       = conv_q;
  assign busy            = (state != S_IDLE) && (state != S_DONE);
  assign done            = (state == S_DONE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_pagerank_iteration_scheduler.sv
// Scoreboard bench for the PageRank iteration scheduler (8-thread and 1-thread builds).
module tb_pagerank_iteration_scheduler;
  import pagerank_pkg::*;

  localparam int N  = 8;
  localparam int IW = 16;
  localparam int SW = 3;
  localparam int BW = SW + 2;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // 8-thread DUT
  logic            start = 0, abort = 0, damp_complete = 0;
  logic [63:0]     epsilon = '0, delta = '0;
  logic [IW-1:0]   max_iterations = '0;
  logic [N-1:0]    thread_start, thread_done = '0;
  logic [SW-1:0]   stream_sel;
  logic            stream_start, stream_done, damp_clear, busy, done, converged;
  logic [IW-1:0]   iteration_count;
  sched_state_t    dbg_state;

  // 1-thread DUT
  logic            s_start = 0, s_abort = 0, s_damp_complete = 0;
  logic [63:0]     s_epsilon = '0, s_delta = '0;
  logic [IW-1:0]   s_max = '0;
  logic [0:0]      s_thread_start, s_thread_done = '0, s_stream_sel;
  logic            s_stream_start, s_stream_done, s_damp_clear, s_busy, s_done, s_converged;
  logic [IW-1:0]   s_iteration_count;
  sched_state_t    s_dbg_state;

  pagerank_iteration_scheduler #(.NUM_HW_THREADS(N), .ITER_W(IW)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .epsilon(epsilon), .max_iterations(max_iterations),
    .thread_start(thread_start), .thread_done(thread_done),
    .stream_sel(stream_sel), .stream_start(stream_start), .stream_done(stream_done),
    .damp_clear(damp_clear), .damp_complete(damp_complete), .delta(delta),
    .iteration_count(iteration_count), .busy(busy), .done(done),
    .converged(converged), .state_dbg(dbg_state)
  );

  pagerank_iteration_scheduler #(.NUM_HW_THREADS(1), .ITER_W(IW)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(s_start), .abort(s_abort),
    .epsilon(s_epsilon), .max_iterations(s_max),
    .thread_start(s_thread_start), .thread_done(s_thread_done),
    .stream_sel(s_stream_sel), .stream_start(s_stream_start), .stream_done(s_stream_done),
    .damp_clear(s_damp_clear), .damp_complete(s_damp_complete), .delta(s_delta),
    .iteration_count(s_iteration_count), .busy(s_busy), .done(s_done),
    .converged(s_converged), .state_dbg(s_dbg_state)
  );

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  logic [IW:0]   res_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int n_clear = 0;
  int n_launch = 0;

  always @(negedge clock) begin
    if (reset_n && damp_clear) n_clear++;
    if (reset_n && thread_start != '0) n_launch++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [63:0] eps, input logic [IW-1:0] mx);
    start = 1'b1;
    epsilon = eps;
    max_iterations = mx;
    tick();
    start = 1'b0;
    epsilon = {$urandom, $urandom};
    max_iterations = IW'($urandom);
  endtask

  // mode 0: full iteration, 1: abort at beat 3, 2: return once in WAIT_DAMP
  task automatic serve_iter(input logic [63:0] dval, input bit launch_done,
                            input bit busy_start, input int mode);
    int k;
    logic [BW-1:0] e;
    k = 0;
    while (damp_clear !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("clear_seen", damp_clear, 1);
    tick();
    check("thread_start", thread_start, {N{1'b1}});
    if (launch_done) begin
      thread_done = '1;
    end else begin
      for (int c = 0; c <= 8; c++) begin
        thread_done = (c == 3) ? 8'h07 : (c == 4) ? 8'h01 : (c == 5) ? 8'h38 :
                      (c == 8) ? 8'hC0 : 8'h00;
        if (c == 6 && busy_start) begin
          start = 1'b1;
          epsilon = '1;
          max_iterations = IW'(1);
        end
        if (c < 8) begin
          check("no_early_stream", stream_start, 0);
          tick();
          start = 1'b0;
        end
      end
    end
    for (int b = 0; b < N; b++) exp_q.push_back({(b == 0), (b == N - 1), SW'(b)});
    tick();
    thread_done = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stream_beat", {stream_start, stream_done, stream_sel}, e);
      if (mode == 1 && e[SW-1:0] == SW'(3)) begin
        abort = 1'b1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        return;
      end
      tick();
    end
    check("wait_damp_sel", stream_sel, 0);
    check("wait_damp_busy", busy, 1);
    if (mode == 2) return;
    if (busy_start) begin
      start = 1'b1;
      epsilon = '1;
    end
    tick();
    start = 1'b0;
    damp_complete = 1'b1;
    delta = dval;
    tick();
    tick();
    damp_complete = 1'b0;
    delta = '0;
  endtask

  task automatic run_case(input string name, input logic [63:0] eps, input logic [IW-1:0] mx,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input bit launch_done, input bit busy_start);
    int cap, iters, c0, l0, k;
    bit conv;
    logic [IW:0] r;
    cap = (mx == 0) ? 1 : int'(mx);
    conv = 0;
    iters = 0;
    for (int i = 1; i <= cap; i++) begin
      iters = i;
      if (((i == 1) ? d0 : d1) < eps) begin
        conv = 1;
        break;
      end
    end
    res_q.push_back({conv, IW'(iters)});
    c0 = n_clear;
    l0 = n_launch;
    do_start(eps, mx);
    for (int i = 0; i < iters; i++)
      serve_iter((i == 0) ? d0 : d1, launch_done, busy_start && i == 0, 0);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_busy"}, busy, 0);
    r = res_q.pop_front();
    check({name, "_result"}, {converged, iteration_count}, r);
    check({name, "_rounds"}, n_clear - c0, iters);
    check({name, "_launches"}, n_launch - l0, iters);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_conv", converged, 0);
    check("rst_iter", iteration_count, 0);
    check("rst_pulses", {thread_start, stream_start, stream_done, damp_clear}, 0);
    check("rst_sel", stream_sel, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    run_case("converge1", 64'h100, 4, 64'h80, 64'h80, 0, 0);
    run_case("cap3", 64'h100, 3, 64'h200, 64'h200, 0, 0);
    run_case("max0", 64'h100, 0, 64'h200, 64'h200, 0, 0);
    run_case("eq_eps", 64'h100, 2, 64'h100, 64'h100, 0, 0);
    run_case("converge2", 64'h100, 5, 64'h300, 64'hFF, 0, 0);
    run_case("launch_done", 64'h40, 2, 64'h41, 64'h3F, 1, 0);
    run_case("busy_start", 64'h100, 3, 64'h200, 64'h200, 0, 1);

    // abort mid-stream, then a clean run
    do_start(64'h100, 4);
    serve_iter(64'h80, 0, 0, 1);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_busy", busy, 0);
    check("abort_no_sdone", stream_done, 0);
    check("abort_sel", stream_sel, 0);
    check("abort_iter", iteration_count, 0);
    tick();
    check("abort_idle_hold", {busy, done, damp_clear}, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", busy, 0);
    run_case("after_abort", 64'h100, 4, 64'h80, 64'h80, 0, 0);

    // async reset while waiting on the damping stage
    do_start(64'h100, 4);
    serve_iter(64'h80, 0, 0, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_outs", {thread_start, stream_start, stream_done, damp_clear, done, converged}, 0);
    check("areset_iter", iteration_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // single-thread build: first beat is also the last
    s_start = 1'b1;
    s_epsilon = 64'h100;
    s_max = 2;
    tick();
    s_start = 1'b0;
    check("n1_clear", s_damp_clear, 1);
    tick();
    check("n1_launch", s_thread_start, 1);
    s_thread_done = 1'b1;
    tick();
    s_thread_done = 1'b0;
    check("n1_stream", {s_stream_start, s_stream_done, s_stream_sel}, 3'b110);
    tick();
    s_damp_complete = 1'b1;
    s_delta = 64'h10;
    tick();
    tick();
    s_damp_complete = 1'b0;
    check("n1_result", {s_done, s_converged, s_iteration_count}, {2'b11, IW'(1)});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
